uart_tx_arbiter: RTL and testbench

//  Shares the single UART transmitter among NREQ byte sources (ALU result path, command echo, error/status).

---
 rtl/uart_tx_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter among NREQ byte sources (index 0 = ALU result).
//   Grants are round-robin, one byte per grant. The arbiter captures the byte,
//   pulses the transmitter start and then waits for tx_done before the next grant.
//
// Ports
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   i_req       per-requester request, held with stable data until its o_ack
//   i_data      flattened request bytes, requester k on i_data[k*N +: N]
//   i_tx_done   one-cycle pulse from the UART TX: byte finished
//   o_ack       one-hot, one-cycle pulse: requester's byte captured
//   o_tx        byte presented to the UART TX (holds the last granted byte)
//   o_tx_start  one-cycle pulse: start UART transmission
//   o_busy      high from capture until the transfer ends
//   o_grant     index of the last/current granted requester
//   o_timeout   one-cycle pulse: tx_done never arrived
//
// Configuration macro: TX_TIMEOUT_EN
//   When defined, the WAIT state gives up after TIMEOUT cycles without i_tx_done.
//   When undefined, WAIT holds indefinitely and o_timeout stays 0.
module uart_tx_arbiter #(
  parameter int N       = 8,
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*N-1:0] i_data,
  input  logic              i_tx_done,
  output logic [NREQ-1:0]   o_ack,
  output logic [N-1:0]      o_tx,
  output logic              o_tx_start,
  output logic              o_busy,
  output logic [2:0]        o_grant,
  output logic              o_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [2:0]      ptr;
  logic [2:0]      ptr_nxt;
  logic [2:0]      ptr_adv;
  logic [2:0]      pick;
  logic [N-1:0]    pick_byte;
  logic            any_req;
  logic            timeout_hit;
  logic [NREQ-1:0] ack_nxt;
  logic [N-1:0]    tx_nxt;
  logic            tx_start_nxt;
  logic            busy_nxt;
  logic [2:0]      grant_nxt;
  logic            timeout_nxt;

  // First set request bit searching upward from base, wrapping at NREQ.
  // The request vector is widened to 8 bits so a 3-bit index always fits.
  function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] req, input logic [2:0] base);
    logic [7:0] req_pad;
    logic [3:0] idx;
    logic [2:0] sel;
    logic       found;
    req_pad = 8'(req);
    sel     = 3'd0;
    found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, base} + 4'(i);
      if (idx >= 4'(NREQ)) begin
        idx = idx - 4'(NREQ);
      end else begin
        idx = idx;
      end
      if (!found && req_pad[idx[2:0]]) begin
        sel   = idx[2:0];
        found = 1'b1;
      end else begin
        sel   = sel;
        found = found;
      end
    end
    return sel;
  endfunction

  // Round-robin selection of the next requester and its byte.
  always_comb begin
    any_req   = |i_req;
    pick      = rr_pick(i_req, ptr);
    pick_byte = {N{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      if (3'(k) == pick) begin
        pick_byte = i_data[k*N +: N];
      end else begin
        pick_byte = pick_byte;
      end
    end
  end

  // Pointer value after a transfer ends: one past the granted requester.
  always_comb begin
    if (o_grant == 3'(NREQ - 1)) begin
      ptr_adv = 3'd0;
    end else begin
      ptr_adv = o_grant + 3'd1;
    end
  end

`ifdef TX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  // Cycles spent in WAIT; held at zero outside WAIT so it restarts on every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= {CW{1'b0}};
    end else if (state != WAIT) begin
      wait_cnt <= {CW{1'b0}};
    end else if (!i_tx_done && (wait_cnt != CW'(TIMEOUT - 1))) begin
      wait_cnt <= wait_cnt + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      wait_cnt <= wait_cnt;
    end
  end

  // Expiry fires on the TIMEOUT-th WAIT edge; a tx_done on that same edge wins.
  assign timeout_hit = (state == WAIT) && !i_tx_done && (wait_cnt == CW'(TIMEOUT - 1));
`else
  localparam int unused_timeout = TIMEOUT;
  assign timeout_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = START;
        end else begin
          state_nxt = IDLE;
        end
      end
      START: state_nxt = WAIT;
      WAIT: begin
        if (i_tx_done || timeout_hit) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs and the rr pointer.
  always_comb begin
    ack_nxt      = {NREQ{1'b0}};
    tx_nxt       = o_tx;
    tx_start_nxt = 1'b0;
    busy_nxt     = o_busy;
    grant_nxt    = o_grant;
    timeout_nxt  = 1'b0;
    ptr_nxt      = ptr;
    case (state)
      IDLE: begin
        if (any_req) begin
          ack_nxt   = NREQ'(1'b1) << pick;
          tx_nxt    = pick_byte;
          grant_nxt = pick;
          busy_nxt  = 1'b1;
        end else begin
          busy_nxt  = o_busy;
        end
      end
      START: tx_start_nxt = 1'b1;
      WAIT: begin
        if (i_tx_done || timeout_hit) begin
          busy_nxt    = 1'b0;
          ptr_nxt     = ptr_adv;
          timeout_nxt = timeout_hit;
        end else begin
          busy_nxt    = o_busy;
        end
      end
      default: ptr_nxt = ptr;
    endcase
  end

  // Output and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_ack      <= {NREQ{1'b0}};
      o_tx       <= {N{1'b0}};
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_grant    <= 3'd0;
      o_timeout  <= 1'b0;
      ptr        <= 3'd0;
    end else begin
      o_ack      <= ack_nxt;
      o_tx       <= tx_nxt;
      o_tx_start <= tx_start_nxt;
      o_busy     <= busy_nxt;
      o_grant    <= grant_nxt;
      o_timeout  <= timeout_nxt;
      ptr        <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int N       = 8;
  localparam int NREQ    = 3;
  localparam int TIMEOUT = 20;
  localparam int DW      = NREQ * N;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] i_req = '0;
  logic [DW-1:0]   i_data = '0;
  logic            i_tx_done = 1'b0;
  logic [NREQ-1:0] o_ack;
  logic [N-1:0]    o_tx;
  logic            o_tx_start;
  logic            o_busy;
  logic [2:0]      o_grant;
  logic            o_timeout;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int timeout_cnt = 0;
  int model_ptr = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_data(i_data), .i_tx_done(i_tx_done),
    .o_ack(o_ack), .o_tx(o_tx), .o_tx_start(o_tx_start), .o_busy(o_busy),
    .o_grant(o_grant), .o_timeout(o_timeout)
  );

  // Count start and timeout pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (o_tx_start === 1'b1) start_cnt <= start_cnt + 1;
    if (o_timeout === 1'b1) timeout_cnt <= timeout_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration rule: first requester at or after the pointer, wrapping.
  function automatic int model_pick(input logic [NREQ-1:0] req, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (req[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  // Drive one full transfer from an idle arbiter and report what was observed.
  task automatic run_txn(input logic [NREQ-1:0] req, input logic [DW-1:0] data, input int delay,
                         input bit hold, output logic [NREQ-1:0] ack, output logic [2:0] grant,
                         output logic [N-1:0] tx, output bit shape_ok, output logic busy_end,
                         output int starts);
    int s0;
    s0 = start_cnt;
    shape_ok = 1'b1;
    i_req = req;
    i_data = data;
    step();
    ack = o_ack;
    grant = o_grant;
    tx = o_tx;
    if (o_busy !== 1'b1 || o_tx_start !== 1'b0) shape_ok = 1'b0;
    if (!hold) i_req = '0;
    step();
    if (o_tx_start !== 1'b1 || o_ack !== '0 || o_busy !== 1'b1 || o_tx !== tx) shape_ok = 1'b0;
    for (int c = 1; c < delay; c++) begin
      step();
      if (o_tx_start !== 1'b0 || o_ack !== '0 || o_busy !== 1'b1 || o_tx !== tx || o_timeout !== 1'b0)
        shape_ok = 1'b0;
    end
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    busy_end = o_busy;
    if (o_tx !== tx || o_timeout !== 1'b0 || o_ack !== '0) shape_ok = 1'b0;
    starts = start_cnt - s0;
  endtask

  task automatic test_reset();
    logic [NREQ-1:0] ack;
    logic [2:0] g;
    logic [N-1:0] tx;
    bit ok;
    logic be;
    int st, s0;
    #12;
    checks++;
    if ({o_ack, o_tx, o_tx_start, o_busy, o_grant, o_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%b tx=%h start=%b busy=%b grant=%0d to=%b, expected all 0",
               o_ack, o_tx, o_tx_start, o_busy, o_grant, o_timeout);
    end
    rst = 1'b0;
    step();
    run_txn(3'b010, {8'h33, 8'h22, 8'h11}, 3, 1'b0, ack, g, tx, ok, be, st);
    checks++;
    if (ack !== 3'b010 || tx !== 8'h22 || !ok || be !== 1'b0 || st != 1) begin
      errors++;
      $display("FAIL reset_pre_txn: got ack=%b tx=%h ok=%0d busy=%b starts=%0d, expected 010/22/1/0/1",
               ack, tx, ok, be, st);
    end
    model_ptr = 2;
    i_req = 3'b100;
    step();
    i_req = '0;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({o_ack, o_tx, o_tx_start, o_busy, o_grant, o_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_mid_wait: got ack=%b tx=%h start=%b busy=%b grant=%0d to=%b, expected all 0",
               o_ack, o_tx, o_tx_start, o_busy, o_grant, o_timeout);
    end
    step();
    rst = 1'b0;
    s0 = start_cnt;
    repeat (5) step();
    checks++;
    if (start_cnt != s0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_quiet: got starts=%0d busy=%b, expected 0 starts busy=0", start_cnt - s0, o_busy);
    end
    model_ptr = 0;
    run_txn(3'b111, {8'hC3, 8'hB2, 8'hA1}, 2, 1'b0, ack, g, tx, ok, be, st);
    checks++;
    if (ack !== 3'b001 || g !== 3'd0 || tx !== 8'hA1 || !ok) begin
      errors++;
      $display("FAIL reset_pointer: got ack=%b grant=%0d tx=%h, expected 001/0/a1", ack, g, tx);
    end
    model_ptr = 1;
  endtask

  task automatic test_single();
    logic [NREQ-1:0] ack;
    logic [2:0] g;
    logic [N-1:0] tx;
    bit ok;
    logic be;
    int st;
    run_txn(3'b001, {8'h00, 8'h00, 8'h30}, 5, 1'b0, ack, g, tx, ok, be, st);
    checks++;
    if (ack !== 3'b001 || tx !== 8'h30 || g !== 3'd0) begin
      errors++;
      $display("FAIL single_capture: got ack=%b tx=%h grant=%0d, expected 001/30/0", ack, tx, g);
    end
    checks++;
    if (!ok || be !== 1'b0 || st != 1) begin
      errors++;
      $display("FAIL single_shape: got ok=%0d busy_end=%b starts=%0d, expected 1/0/1", ok, be, st);
    end
    model_ptr = 1;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] ack;
    logic [2:0] g;
    logic [N-1:0] tx;
    bit ok;
    logic be;
    int st;
    logic [7:0] exp_b [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hAA};
    int exp_g [4] = '{0, 1, 2, 0};
    run_txn(3'b100, {8'h5C, 8'h00, 8'h00}, 2, 1'b0, ack, g, tx, ok, be, st);
    checks++;
    if (ack !== 3'b100 || tx !== 8'h5C) begin
      errors++;
      $display("FAIL rr_prep: got ack=%b tx=%h, expected 100/5c", ack, tx);
    end
    for (int i = 0; i < 4; i++) begin
      run_txn(3'b111, {8'hCC, 8'hBB, 8'hAA}, 10, 1'b1, ack, g, tx, ok, be, st);
      checks++;
      if (tx !== exp_b[i] || g !== 3'(exp_g[i]) || !ok || be !== 1'b0 || st != 1) begin
        errors++;
        $display("FAIL rr_order[%0d]: got tx=%h grant=%0d ok=%0d starts=%0d, expected %h/%0d",
                 i, tx, g, ok, st, exp_b[i], exp_g[i]);
      end
    end
    i_req = '0;
    model_ptr = 1;
  endtask

  task automatic test_pointer_wrap();
    logic [NREQ-1:0] ack;
    logic [2:0] g;
    logic [N-1:0] tx;
    bit ok;
    logic be;
    int st;
    logic [NREQ-1:0] reqs [4] = '{3'b100, 3'b101, 3'b101, 3'b101};
    int exp_g [4] = '{2, 0, 2, 0};
    for (int i = 0; i < 4; i++) begin
      run_txn(reqs[i], {8'h72, 8'h71, 8'h70}, 3, 1'b0, ack, g, tx, ok, be, st);
      checks++;
      if (g !== 3'(exp_g[i]) || tx !== 8'(8'h70 + exp_g[i]) || !ok) begin
        errors++;
        $display("FAIL wrap[%0d]: got grant=%0d tx=%h ok=%0d, expected grant=%0d", i, g, tx, ok, exp_g[i]);
      end
    end
    model_ptr = 1;
  endtask

  task automatic test_stray_done();
    int s0;
    i_req = '0;
    s0 = start_cnt;
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    step();
    step();
    checks++;
    if (start_cnt != s0 || o_busy !== 1'b0 || o_ack !== '0) begin
      errors++;
      $display("FAIL stray_idle: got starts=%0d busy=%b ack=%b, expected 0/0/000", start_cnt - s0, o_busy, o_ack);
    end
    i_req = 3'b001;
    i_data = {8'h00, 8'h00, 8'h5A};
    step();
    i_req = '0;
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    checks++;
    if (o_tx_start !== 1'b1 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL stray_start: got start=%b busy=%b, expected 1/1", o_tx_start, o_busy);
    end
    repeat (3) step();
    checks++;
    if (o_busy !== 1'b1 || o_tx !== 8'h5A) begin
      errors++;
      $display("FAIL stray_still_wait: got busy=%b tx=%h, expected 1/5a", o_busy, o_tx);
    end
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || start_cnt != s0 + 1) begin
      errors++;
      $display("FAIL stray_end: got busy=%b starts=%0d, expected 0/1", o_busy, start_cnt - s0);
    end
    model_ptr = 1;
  endtask

  task automatic test_req_during_wait();
    int s0, acks;
    i_req = 3'b001;
    i_data = {8'h03, 8'h02, 8'h01};
    step();
    checks++;
    if (o_ack !== 3'b001) begin
      errors++;
      $display("FAIL rdw_ack: got %b expected 001", o_ack);
    end
    i_req = '0;
    step();
    i_req = 3'b110;
    step();
    step();
    i_req = '0;
    step();
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    s0 = start_cnt;
    acks = 0;
    repeat (5) begin
      step();
      if (o_ack !== '0) acks++;
    end
    checks++;
    if (acks != 0 || start_cnt != s0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL rdw_ignored: got acks=%0d starts=%0d busy=%b, expected 0/0/0", acks, start_cnt - s0, o_busy);
    end
    model_ptr = 1;
  endtask

  task automatic test_timeout();
    bit bad;
    int t0;
    t0 = timeout_cnt;
    bad = 1'b0;
    i_req = 3'b010;
    i_data = {8'h93, 8'h92, 8'h91};
    step();
    i_req = '0;
    step();
`ifdef TX_TIMEOUT_EN
    repeat (TIMEOUT - 1) begin
      step();
      if (o_timeout !== 1'b0 || o_busy !== 1'b1) bad = 1'b1;
    end
    step();
    checks++;
    if (bad || o_timeout !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: got early=%0d to=%b busy=%b, expected 0/1/0", bad, o_timeout, o_busy);
    end
    step();
    checks++;
    if (o_timeout !== 1'b0 || timeout_cnt != t0 + 1) begin
      errors++;
      $display("FAIL timeout_width: got to=%b pulses=%0d, expected 0/1", o_timeout, timeout_cnt - t0);
    end
    model_ptr = 2;
    i_req = 3'b111;
    step();
    i_req = '0;
    checks++;
    if (o_grant !== 3'd2 || o_tx !== 8'h93) begin
      errors++;
      $display("FAIL timeout_next: got grant=%0d tx=%h, expected 2/93", o_grant, o_tx);
    end
    step();
    repeat (TIMEOUT - 2) step();
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    checks++;
    if (o_timeout !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_done_wins: got to=%b busy=%b, expected 0/0", o_timeout, o_busy);
    end
    model_ptr = 0;
`else
    repeat (TIMEOUT + 10) begin
      step();
      if (o_timeout !== 1'b0 || o_busy !== 1'b1) bad = 1'b1;
    end
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    checks++;
    if (bad || o_busy !== 1'b0 || timeout_cnt != t0) begin
      errors++;
      $display("FAIL no_timeout: got gave_up=%0d busy=%b pulses=%0d, expected 0/0/0", bad, o_busy, timeout_cnt - t0);
    end
    model_ptr = 2;
`endif
  endtask

  task automatic test_random();
    logic [NREQ-1:0] ack, req, e_ack;
    logic [2:0] g;
    logic [N-1:0] tx, e_byte;
    logic [DW-1:0] data;
    bit ok, hold;
    logic be;
    int st, e, delay;
    for (int i = 0; i < 40; i++) begin
      req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      data = DW'($urandom());
      delay = int'($urandom_range(1, 12));
      hold = 1'($urandom_range(0, 1));
      e = model_pick(req, model_ptr);
      e_ack = '0;
      e_ack[e] = 1'b1;
      e_byte = data[e*N +: N];
      run_txn(req, data, delay, hold, ack, g, tx, ok, be, st);
      i_req = '0;
      checks++;
      if (ack !== e_ack || g !== 3'(e) || tx !== e_byte) begin
        errors++;
        $display("FAIL rand[%0d] grant: req=%b got ack=%b grant=%0d tx=%h, expected %b/%0d/%h",
                 i, req, ack, g, tx, e_ack, e, e_byte);
      end
      checks++;
      if (!ok || be !== 1'b0 || st != 1) begin
        errors++;
        $display("FAIL rand[%0d] shape: got ok=%0d busy_end=%b starts=%0d, expected 1/0/1", i, ok, be, st);
      end
      model_ptr = (e + 1) % NREQ;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pointer_wrap();
    test_stray_done();
    test_req_during_wait();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
